lsu_ctrl: RTL and testbench

- CPU-side load/store initiator that drives the data memory's csen/wren/MemOp-style port.
- Accepts one load or store request at a time from the execute stage.
- Performs word-address generation, read-modify-write for byte and halfword stores, lane extraction and sign/zero extension for loads, and alignment checking.
- Returns one response per request.

---
 rtl/lsu_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: CPU-side load/store initiator for a csen/wren word-wide data memory.
// Handles one request at a time. Loads are extracted and sign- or zero-extended
// from the addressed lane. Byte and halfword stores are done as a read-modify-write.
// Word stores skip the read.
// Optional build macro: LSU_MISALIGN_TRAP_EN. When it is defined, misaligned word
// and half accesses return rsp_err without any memory access. When it is not
// defined, the unused low address bits are ignored and the access proceeds.
// Illegal memop codes return an error in both builds.
module lsu_ctrl #(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned AW     = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [2:0]    req_memop,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          mem_csen,
  output logic          mem_wren,
  output logic [AW-3:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_RWAIT = 3'd2,
    S_WR    = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

  state_e        state_q;
  logic          wr_q;
  logic [2:0]    memop_q;
  logic [1:0]    lane_q;
  logic [31:0]   wdata_q;
  logic [1:0]    cnt_q;

  logic          req_ready_q;
  logic          rsp_valid_q;
  logic [31:0]   rsp_rdata_q;
  logic          rsp_err_q;
  logic          mem_csen_q;
  logic          mem_wren_q;
  logic [AW-3:0] mem_addr_q;
  logic [31:0]   mem_wdata_q;

  logic          illegal_d;
  logic          misalign_d;
  logic          req_err_d;
  logic [7:0]    byte_sel_d;
  logic [15:0]   half_sel_d;
  logic [31:0]   load_d;
  logic [31:0]   merge_d;

  // Classify the incoming request: illegal memop code or (optionally) misaligned
  always_comb begin
    illegal_d  = (req_memop == 3'b011) || (req_memop == 3'b100) ||
                 (req_memop == 3'b111);
    misalign_d = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (req_memop[1:0] == SZ_WORD) begin
      misalign_d = (req_addr[1:0] != 2'b00);
    end else if (req_memop[1:0] == SZ_HALF) begin
      misalign_d = req_addr[0];
    end
`endif
    req_err_d  = illegal_d | misalign_d;
  end

  // Lane selection from the returned word, then extension for loads
  always_comb begin
    case (lane_q)
      2'd0:    byte_sel_d = mem_rdata[7:0];
      2'd1:    byte_sel_d = mem_rdata[15:8];
      2'd2:    byte_sel_d = mem_rdata[23:16];
      default: byte_sel_d = mem_rdata[31:24];
    endcase
    half_sel_d = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (memop_q[1:0])
      SZ_BYTE: load_d = memop_q[2] ? {{24{1'b0}}, byte_sel_d}
                                   : {{24{byte_sel_d[7]}}, byte_sel_d};
      SZ_HALF: load_d = memop_q[2] ? {{16{1'b0}}, half_sel_d}
                                   : {{16{half_sel_d[15]}}, half_sel_d};
      default: load_d = mem_rdata;
    endcase
  end

  // Merge the store data into the word just read (sub-word stores only)
  always_comb begin
    merge_d = mem_rdata;
    case (memop_q[1:0])
      SZ_BYTE: begin
        case (lane_q)
          2'd0:    merge_d[7:0]   = wdata_q[7:0];
          2'd1:    merge_d[15:8]  = wdata_q[7:0];
          2'd2:    merge_d[23:16] = wdata_q[7:0];
          default: merge_d[31:24] = wdata_q[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane_q[1]) merge_d[31:16] = wdata_q[15:0];
        else           merge_d[15:0]  = wdata_q[15:0];
      end
      default: merge_d = wdata_q;
    endcase
  end

  // Control FSM; every output is a register loaded on entry to the state that owns it.
  // The read word is folded into rsp_rdata_q (loads) or mem_wdata_q (stores) at the
  // capture edge, so those registers also serve as the read holding register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      wr_q        <= 1'b0;
      memop_q     <= '0;
      lane_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_csen_q  <= 1'b0;
      mem_wren_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_csen_q  <= 1'b0;
      mem_wren_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            wr_q        <= req_wr;
            memop_q     <= req_memop;
            lane_q      <= req_addr[1:0];
            wdata_q     <= req_wdata;
            mem_addr_q  <= req_addr[AW-1:2];
            req_ready_q <= 1'b0;
            if (req_err_d) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else if (req_wr && (req_memop[1:0] == SZ_WORD)) begin
              state_q     <= S_WR;
              mem_csen_q  <= 1'b1;
              mem_wren_q  <= 1'b1;
              mem_wdata_q <= req_wdata;
            end else begin
              state_q    <= S_RD;
              mem_csen_q <= 1'b1;
            end
          end
        end
        S_RD: begin
          state_q <= S_RWAIT;
          cnt_q   <= WAIT_INIT;
        end
        S_RWAIT: begin
          if (cnt_q == 2'd0) begin
            if (wr_q) begin
              state_q     <= S_WR;
              mem_csen_q  <= 1'b1;
              mem_wren_q  <= 1'b1;
              mem_wdata_q <= merge_d;
            end else begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= load_d;
            end
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        S_WR: begin
          state_q     <= S_RESP;
          rsp_valid_q <= 1'b1;
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_csen  = mem_csen_q;
  assign mem_wren  = mem_wren_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl. There are two instances: RD_LAT=1 (dut) and
// RD_LAT=3 (dut3). Each instance has its own word memory model. sel3 routes the
// shared request stimulus to one instance and muxes that instance's outputs back.
module tb_lsu_ctrl;

  localparam int unsigned L1 = 1;
  localparam int unsigned L3 = 3;

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic        req_wr;
  logic [2:0]  req_memop;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        sel3;

  logic        v1, v3;
  logic        r1_ready, r1_rsp_valid, r1_rsp_err, m1_csen, m1_wren;
  logic [31:0] r1_rsp_rdata, m1_wdata, m1_rdata;
  logic [13:0] m1_addr;
  logic        r3_ready, r3_rsp_valid, r3_rsp_err, m3_csen, m3_wren;
  logic [31:0] r3_rsp_rdata, m3_wdata, m3_rdata;
  logic [13:0] m3_addr;

  logic        t_ready, t_rsp_valid, t_rsp_err, t_csen, t_wren;
  logic [31:0] t_rsp_rdata;

  logic [31:0] mem1 [0:255];
  logic [31:0] pipe1 [0:L1-1];
  logic [31:0] mem3 [0:255];
  logic [31:0] pipe3 [0:L3-1];

  int n_checks = 0;
  int n_errors = 0;
  int g_wr1 = 0;
  int g_bad = 0;

  assign v1 = req_valid & ~sel3;
  assign v3 = req_valid &  sel3;
  assign t_ready     = sel3 ? r3_ready     : r1_ready;
  assign t_rsp_valid = sel3 ? r3_rsp_valid : r1_rsp_valid;
  assign t_rsp_err   = sel3 ? r3_rsp_err   : r1_rsp_err;
  assign t_rsp_rdata = sel3 ? r3_rsp_rdata : r1_rsp_rdata;
  assign t_csen      = sel3 ? m3_csen      : m1_csen;
  assign t_wren      = sel3 ? m3_wren      : m1_wren;

  lsu_ctrl #(.RD_LAT(L1), .AW(16)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(v1), .req_ready(r1_ready), .req_wr(req_wr), .req_memop(req_memop),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(r1_rsp_valid), .rsp_rdata(r1_rsp_rdata), .rsp_err(r1_rsp_err),
    .mem_csen(m1_csen), .mem_wren(m1_wren), .mem_addr(m1_addr),
    .mem_wdata(m1_wdata), .mem_rdata(m1_rdata)
  );

  lsu_ctrl #(.RD_LAT(L3), .AW(16)) dut3 (
    .clk(clk), .rstn(rstn),
    .req_valid(v3), .req_ready(r3_ready), .req_wr(req_wr), .req_memop(req_memop),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(r3_rsp_valid), .rsp_rdata(r3_rsp_rdata), .rsp_err(r3_rsp_err),
    .mem_csen(m3_csen), .mem_wren(m3_wren), .mem_addr(m3_addr),
    .mem_wdata(m3_wdata), .mem_rdata(m3_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: the write commits at the edge. Read data appears RD_LAT cycles
  // after the issue cycle. Cycles without a read shift in filler, so a mistimed
  // capture returns visibly wrong data.
  always @(posedge clk) begin
    if (m1_csen && m1_wren) mem1[m1_addr[7:0]] <= m1_wdata;
    pipe1[0] <= (m1_csen && !m1_wren) ? mem1[m1_addr[7:0]] : 32'h5A5A5A5A;
    for (int i = 1; i < L1; i++) pipe1[i] <= pipe1[i-1];
    if (m1_csen && m1_wren) g_wr1 <= g_wr1 + 1;
    if ((m1_wren && !m1_csen) || (m3_wren && !m3_csen)) g_bad <= g_bad + 1;
  end
  assign m1_rdata = pipe1[L1-1];

  always @(posedge clk) begin
    if (m3_csen && m3_wren) mem3[m3_addr[7:0]] <= m3_wdata;
    pipe3[0] <= (m3_csen && !m3_wren) ? mem3[m3_addr[7:0]] : 32'h5A5A5A5A;
    for (int i = 1; i < L3; i++) pipe3[i] <= pipe3[i-1];
  end
  assign m3_rdata = pipe3[L3-1];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One request. Latency counts cycles from the accept cycle (cycle 0) to the
  // rsp_valid cycle. Memory reads and writes are counted over that window.
  task automatic txn(input string tag, input logic wr, input logic [2:0] op,
                     input logic [15:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err,
                     input int exp_lat, input int exp_nrd, input int exp_nwr);
    int          lat, nrd, nwr;
    logic [31:0] rd;
    logic        err;
    logic        done;
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_memop = op; req_addr = addr; req_wdata = wd;
    for (int g = 0; g < 20 && !t_ready; g++) @(negedge clk);
    check_eq({tag, "_accept"}, 32'(t_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; nrd = 0; nwr = 0; rd = '0; err = 1'b0; done = 1'b0;
    for (int g = 0; g < 30 && !done; g++) begin
      if (t_csen && !t_wren) nrd++;
      if (t_csen && t_wren) nwr++;
      if (t_rsp_valid) begin
        rd = t_rsp_rdata; err = t_rsp_err; done = 1'b1;
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    check_eq({tag, "_done"}, 32'(done), 32'd1);
    check_eq({tag, "_rdata"}, rd, exp_rd);
    check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_nrd"}, 32'(nrd), 32'(exp_nrd));
    check_eq({tag, "_nwr"}, 32'(nwr), 32'(exp_nwr));
  endtask

  initial begin
    int c_rsp, c_rdy, wr_before, lat;
    logic done;
    rstn = 1'b0; sel3 = 1'b0; req_valid = 1'b0; req_wr = 1'b0;
    req_memop = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 32'(r1_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(r1_rsp_valid), 32'd0);
    check_eq("rst_csen", 32'(m1_csen), 32'd0);
    check_eq("rst_wren", 32'(m1_wren), 32'd0);
    check_eq("rst_addr", 32'(m1_addr), 32'd0);
    check_eq("rst_wdata", m1_wdata, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Word store and load back
    txn("st_word", 1'b1, 3'b000, 16'h0010, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, 1);
    check_eq("st_word_mem", mem1[4], 32'hDEADBEEF);
    txn("ld_word", 1'b0, 3'b000, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1, 0);

    // Byte store read-modify-write
    txn("st_w2", 1'b1, 3'b000, 16'h0010, 32'h11223344, 32'h0, 1'b0, 2, 0, 1);
    txn("st_byte", 1'b1, 3'b001, 16'h0013, 32'h000000AA, 32'h0, 1'b0, 4, 1, 1);
    check_eq("st_byte_mem", mem1[4], 32'hAA223344);

    // Load extraction and extension
    txn("st_w3", 1'b1, 3'b000, 16'h0020, 32'h80FF7F01, 32'h0, 1'b0, 2, 0, 1);
    txn("lb_21", 1'b0, 3'b001, 16'h0021, 32'h0, 32'h0000007F, 1'b0, 3, 1, 0);
    txn("lb_22", 1'b0, 3'b001, 16'h0022, 32'h0, 32'hFFFFFFFF, 1'b0, 3, 1, 0);
    txn("lbu_23", 1'b0, 3'b101, 16'h0023, 32'h0, 32'h00000080, 1'b0, 3, 1, 0);
    txn("lh_22", 1'b0, 3'b010, 16'h0022, 32'h0, 32'hFFFF80FF, 1'b0, 3, 1, 0);
    txn("lhu_20", 1'b0, 3'b110, 16'h0020, 32'h0, 32'h00007F01, 1'b0, 3, 1, 0);
    txn("lbu_20", 1'b0, 3'b101, 16'h0020, 32'h0, 32'h00000001, 1'b0, 3, 1, 0);

    // Half stores into both halves
    txn("st_w4", 1'b1, 3'b000, 16'h0030, 32'hCAFEF00D, 32'h0, 1'b0, 2, 0, 1);
    txn("sh_32", 1'b1, 3'b010, 16'h0032, 32'h00001234, 32'h0, 1'b0, 4, 1, 1);
    check_eq("sh_32_mem", mem1[12], 32'h1234F00D);
    txn("sh_30", 1'b1, 3'b110, 16'h0030, 32'hFFFF5678, 32'h0, 1'b0, 4, 1, 1);
    check_eq("sh_30_mem", mem1[12], 32'h12345678);

    // Illegal memop codes error in every build
    txn("ill_111", 1'b0, 3'b111, 16'h0040, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    txn("ill_011", 1'b1, 3'b011, 16'h0010, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    txn("ill_100", 1'b0, 3'b100, 16'h0020, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    check_eq("ill_mem", mem1[4], 32'hAA223344);

    // Misaligned accesses
`ifdef LSU_MISALIGN_TRAP_EN
    txn("mis_lh", 1'b0, 3'b010, 16'h0031, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    txn("mis_sw", 1'b1, 3'b000, 16'h0032, 32'h55667788, 32'h0, 1'b1, 1, 0, 0);
    check_eq("mis_sw_mem", mem1[12], 32'h12345678);
`else
    txn("mis_lh", 1'b0, 3'b010, 16'h0031, 32'h0, 32'h00005678, 1'b0, 3, 1, 0);
    txn("mis_sw", 1'b1, 3'b000, 16'h0032, 32'h55667788, 32'h0, 1'b0, 2, 0, 1);
    check_eq("mis_sw_mem", mem1[12], 32'h55667788);
`endif

    // Reset during RWAIT of a half store
    txn("st_w5", 1'b1, 3'b000, 16'h0040, 32'h01020304, 32'h0, 1'b0, 2, 0, 1);
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_memop = 3'b010; req_addr = 16'h0042;
    req_wdata = 32'h0000BEEF;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("rw_rd_csen", 32'(m1_csen), 32'd1);
    @(negedge clk);
    check_eq("rw_wait_csen", 32'(m1_csen), 32'd0);
    wr_before = g_wr1;
    rstn = 1'b0;
    #1;
    check_eq("rw_ready", 32'(r1_ready), 32'd1);
    check_eq("rw_rsp_valid", 32'(r1_rsp_valid), 32'd0);
    check_eq("rw_rsp_rdata", r1_rsp_rdata, 32'd0);
    check_eq("rw_rsp_err", 32'(r1_rsp_err), 32'd0);
    check_eq("rw_csen", 32'(m1_csen), 32'd0);
    check_eq("rw_addr", 32'(m1_addr), 32'd0);
    check_eq("rw_wdata", m1_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("rw_no_write", 32'(g_wr1), 32'(wr_before));
    check_eq("rw_mem", mem1[16], 32'h01020304);
    txn("rw_again", 1'b1, 3'b010, 16'h0042, 32'h0000BEEF, 32'h0, 1'b0, 4, 1, 1);
    check_eq("rw_again_mem", mem1[16], 32'hBEEF0304);

    // Back-to-back: req_valid held high, second request waits for IDLE
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_memop = 3'b000; req_addr = 16'h0020;
    @(negedge clk);
    req_memop = 3'b101; req_addr = 16'h0013;
    c_rsp = -1; c_rdy = -1;
    for (int cyc = 1; cyc < 30 && c_rdy < 0; cyc++) begin
      if (t_rsp_valid && c_rsp < 0) begin
        c_rsp = cyc;
        check_eq("b2b_a_rdata", t_rsp_rdata, 32'h80FF7F01);
      end
      if (t_ready) c_rdy = cyc;
      else @(negedge clk);
    end
    check_eq("b2b_rsp_cyc", 32'(c_rsp), 32'd3);
    check_eq("b2b_rdy_cyc", 32'(c_rdy), 32'd4);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; done = 1'b0;
    for (int g = 0; g < 30 && !done; g++) begin
      if (t_rsp_valid) begin
        done = 1'b1;
        check_eq("b2b_b_rdata", t_rsp_rdata, 32'h000000AA);
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    check_eq("b2b_b_lat", 32'(lat), 32'd3);

    // RD_LAT=3 instance
    sel3 = 1'b1;
    txn("l3_sw", 1'b1, 3'b000, 16'h0008, 32'h0BADF00D, 32'h0, 1'b0, 2, 0, 1);
    txn("l3_lw", 1'b0, 3'b000, 16'h0008, 32'h0, 32'h0BADF00D, 1'b0, 5, 1, 0);
    txn("l3_lb", 1'b0, 3'b001, 16'h000B, 32'h0, 32'h0000000B, 1'b0, 5, 1, 0);
    txn("l3_sb", 1'b1, 3'b001, 16'h0009, 32'h0000005A, 32'h0, 1'b0, 6, 1, 1);
    txn("l3_lw2", 1'b0, 3'b000, 16'h0008, 32'h0, 32'h0BAD5A0D, 1'b0, 5, 1, 0);
    sel3 = 1'b0;

    check_eq("wren_without_csen", 32'(g_bad), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
